rx_interrupt_moderator_mc: RTL and testbench

- Multi-channel successor to the single-queue Rx interrupt generator.
- Each of NUM_CH channels independently coalesces Rx events (packet-count threshold plus timeout) and applies a post-interrupt holdoff.
- A round-robin arbiter serialises the resulting requests onto the single Virtex-5 PCIe endpoint legacy/MSI interface (cfg_interrupt_n / cfg_interrupt_rdy_n / cfg_interrupt_di), carrying the channel index as the MSI vector.
- Sits between the per-queue Rx DMA engines and the PCIe core configuration port.

---
 rtl/rx_interrupt_moderator_mc.sv | 215 +++++++++++++++++++++
 tb/tb_rx_interrupt_moderator_mc.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_interrupt_moderator_mc.sv
// rx_interrupt_moderator_mc
// Multi-channel Rx interrupt moderator. Each channel coalesces Rx events
// (packet-count threshold plus timeout) and enforces a holdoff after every
// interrupt. A round-robin arbiter serialises the channel requests onto the
// single PCIe endpoint interrupt interface, carrying the channel index as the
// MSI vector.
//
// Ports:
//   clk, reset_n           core clock, asynchronous active-low reset
//   cfg_interrupt_n        interrupt request to the PCIe core (active low)
//   cfg_interrupt_rdy_n    core acknowledge (active low)
//   cfg_interrupt_di       MSI vector = granted channel index
//   ch_event               per-channel Rx activity level (may be asynchronous)
//   ch_ready               per-channel host buffer valid
//   ch_enable              per-channel interrupt enable
//   pkt_threshold          events per interrupt (0 behaves as 1)
//   coalesce_timeout       max cycles from first event to request
//   interrupt_period       holdoff after each interrupt
//   resend_req             host-requested re-interrupt (level)
//   resend_ack             one-cycle acknowledge per channel
module rx_interrupt_moderator_mc #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned PKT_W  = 16,
  parameter int unsigned VEC_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              cfg_interrupt_n,
  input  logic              cfg_interrupt_rdy_n,
  output logic [VEC_W-1:0]  cfg_interrupt_di,
  input  logic [NUM_CH-1:0] ch_event,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [PKT_W-1:0]  pkt_threshold,
  input  logic [CNT_W-1:0]  coalesce_timeout,
  input  logic [CNT_W-1:0]  interrupt_period,
  input  logic [NUM_CH-1:0] resend_req,
  output logic [NUM_CH-1:0] resend_ack
);

  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {CH_IDLE, CH_ARMED, CH_REQ, CH_HOLD} ch_state_t;
  typedef enum logic {A_IDLE, A_WAIT} arb_state_t;

  logic [PKT_W-1:0]  thr_q, thr_eff;
  logic [CNT_W-1:0]  timeout_q, period_q;
  logic [NUM_CH-1:0] sync1, sync2, sync3, rise;

  ch_state_t         ch_st [NUM_CH];
  ch_state_t         ch_st_nxt [NUM_CH];
  logic [PKT_W-1:0]  cnt [NUM_CH];
  logic [PKT_W-1:0]  cnt_nxt [NUM_CH];
  logic [CNT_W-1:0]  tmr [NUM_CH];
  logic [CNT_W-1:0]  tmr_nxt [NUM_CH];
  logic [NUM_CH-1:0] force_q, force_nxt, ack_nxt;
  logic [NUM_CH-1:0] eligible, drop, done;

  arb_state_t        arb_st, arb_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt, cand, gnt_idx, wait_idx, wait_idx_nxt;
  logic              gnt_valid, gnt_issue, cfg_n_nxt;
  logic [VEC_W-1:0]  di_nxt;

  // Config registers and event synchroniser (sync3 is the edge-detect delay).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      thr_q     <= '0;
      timeout_q <= '0;
      period_q  <= '0;
      sync1     <= '0;
      sync2     <= '0;
      sync3     <= '0;
    end else begin
      thr_q     <= pkt_threshold;
      timeout_q <= coalesce_timeout;
      period_q  <= interrupt_period;
      sync1     <= ch_event;
      sync2     <= sync1;
      sync3     <= sync2;
    end
  end

  always_comb begin
    rise    = sync2 & ~sync3;
    thr_eff = (thr_q == '0) ? PKT_W'(1) : thr_q;
  end

  // Arbiter next-state. A forced-but-disabled channel is simply not eligible,
  // so the search skips it instead of stalling on it.
  always_comb begin
    cand         = '0;
    gnt_valid    = 1'b0;
    gnt_idx      = '0;
    drop         = '0;
    done         = '0;
    arb_nxt      = arb_st;
    ptr_nxt      = ptr;
    wait_idx_nxt = wait_idx;
    cfg_n_nxt    = cfg_interrupt_n;
    di_nxt       = cfg_interrupt_di;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      eligible[i] = (ch_st[i] == CH_REQ) && (!force_q[i] || ch_enable[i]);
    end
    if (arb_st == A_IDLE) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        cand = PTR_W'((32'(ptr) + k) % NUM_CH);
        if (!gnt_valid && eligible[cand]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
    gnt_issue = force_q[gnt_idx] | (ch_enable[gnt_idx] & ch_ready[gnt_idx]);
    case (arb_st)
      A_IDLE: begin
        if (gnt_valid) begin
          ptr_nxt = (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
          if (gnt_issue) begin
            cfg_n_nxt    = 1'b0;
            di_nxt       = VEC_W'(gnt_idx);
            wait_idx_nxt = gnt_idx;
            arb_nxt      = A_WAIT;
          end else begin
            drop[gnt_idx] = 1'b1;
          end
        end
      end
      A_WAIT: begin
        if (!cfg_interrupt_rdy_n) begin
          cfg_n_nxt      = 1'b1;
          done[wait_idx] = 1'b1;
          arb_nxt        = A_IDLE;
        end
      end
    endcase
  end

  // Per-channel next-state. Events are counted in every state; entering HOLD
  // clears the count so only events arriving during the holdoff re-arm it.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_st_nxt[i] = ch_st[i];
      cnt_nxt[i]   = cnt[i];
      tmr_nxt[i]   = tmr[i];
      force_nxt[i] = force_q[i];
      ack_nxt[i]   = 1'b0;
      if (rise[i] && (cnt[i] != '1)) cnt_nxt[i] = cnt[i] + 1'b1;
      case (ch_st[i])
        CH_IDLE: begin
          if (rise[i]) begin
            ch_st_nxt[i] = CH_ARMED;
            cnt_nxt[i]   = PKT_W'(1);
            tmr_nxt[i]   = '0;
          end else if (resend_req[i]) begin
            ack_nxt[i]   = 1'b1;
            force_nxt[i] = 1'b1;
            ch_st_nxt[i] = CH_REQ;
          end
        end
        CH_ARMED: begin
          if ((cnt[i] >= thr_eff) || (tmr[i] == timeout_q)) ch_st_nxt[i] = CH_REQ;
          else tmr_nxt[i] = tmr[i] + 1'b1;
        end
        CH_REQ: begin
          if (drop[i] || done[i]) begin
            ch_st_nxt[i] = CH_HOLD;
            force_nxt[i] = 1'b0;
            cnt_nxt[i]   = '0;
            tmr_nxt[i]   = '0;
          end
        end
        CH_HOLD: begin
          if (tmr[i] == period_q) begin
            tmr_nxt[i]   = '0;
            ch_st_nxt[i] = (cnt_nxt[i] != '0) ? CH_ARMED : CH_IDLE;
          end else begin
            tmr_nxt[i] = tmr[i] + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        ch_st[i] <= CH_IDLE;
        cnt[i]   <= '0;
        tmr[i]   <= '0;
      end
      force_q          <= '0;
      resend_ack       <= '0;
      arb_st           <= A_IDLE;
      ptr              <= '0;
      wait_idx         <= '0;
      cfg_interrupt_n  <= 1'b1;
      cfg_interrupt_di <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        ch_st[i] <= ch_st_nxt[i];
        cnt[i]   <= cnt_nxt[i];
        tmr[i]   <= tmr_nxt[i];
      end
      force_q          <= force_nxt;
      resend_ack       <= ack_nxt;
      arb_st           <= arb_nxt;
      ptr              <= ptr_nxt;
      wait_idx         <= wait_idx_nxt;
      cfg_interrupt_n  <= cfg_n_nxt;
      cfg_interrupt_di <= di_nxt;
    end
  end

endmodule

// File: tb/tb_rx_interrupt_moderator_mc.sv
// Directed testbench for rx_interrupt_moderator_mc (NUM_CH=4, default widths).
module tb_rx_interrupt_moderator_mc;

  logic        clk;
  logic        reset_n;
  logic        cfg_interrupt_n;
  logic        cfg_interrupt_rdy_n;
  logic [7:0]  cfg_interrupt_di;
  logic [3:0]  ch_event, ch_ready, ch_enable, resend_req, resend_ack;
  logic [15:0] pkt_threshold;
  logic [31:0] coalesce_timeout, interrupt_period;

  int errors = 0;
  int checks = 0;

  rx_interrupt_moderator_mc #(.NUM_CH(4), .CNT_W(32), .PKT_W(16), .VEC_W(8)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .cfg_interrupt_n     (cfg_interrupt_n),
    .cfg_interrupt_rdy_n (cfg_interrupt_rdy_n),
    .cfg_interrupt_di    (cfg_interrupt_di),
    .ch_event            (ch_event),
    .ch_ready            (ch_ready),
    .ch_enable           (ch_enable),
    .pkt_threshold       (pkt_threshold),
    .coalesce_timeout    (coalesce_timeout),
    .interrupt_period    (interrupt_period),
    .resend_req          (resend_req),
    .resend_ack          (resend_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_now();
    cfg_interrupt_rdy_n = 1'b0;
    tick();
    cfg_interrupt_rdy_n = 1'b1;
  endtask

  // Returns the number of ticks until cfg_interrupt_n is seen low, -1 on timeout.
  task automatic wait_cfg_low(input int max_ticks, output int n);
    n = -1;
    for (int t = 1; t <= max_ticks; t++) begin
      tick();
      if (cfg_interrupt_n === 1'b0) begin
        n = t;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    checks++; if (cfg_interrupt_n !== 1'b1) begin errors++; $display("FAIL reset_cfg_n: got %b expected 1", cfg_interrupt_n); end
    checks++; if (cfg_interrupt_di !== 8'h00) begin errors++; $display("FAIL reset_di: got %0h expected 0", cfg_interrupt_di); end
    checks++; if (resend_ack !== 4'b0000) begin errors++; $display("FAIL reset_resend_ack: got %b expected 0000", resend_ack); end
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    checks++; if (cfg_interrupt_n !== 1'b1) begin errors++; $display("FAIL post_reset_idle: got %b expected 1", cfg_interrupt_n); end
  endtask

  task automatic test_threshold_issue();
    ch_event[2] = 1'b1;
    tick();
    ch_event[2] = 1'b0;
    repeat (3) tick();
    checks++; if (cfg_interrupt_n !== 1'b1) begin errors++; $display("FAIL latency_early: got %b expected 1 at cycle 4", cfg_interrupt_n); end
    tick();
    checks++; if (cfg_interrupt_n !== 1'b0) begin errors++; $display("FAIL latency_5: got %b expected 0 at cycle 5", cfg_interrupt_n); end
    checks++; if (cfg_interrupt_di !== 8'd2) begin errors++; $display("FAIL issue_di: got %0d expected 2", cfg_interrupt_di); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (cfg_interrupt_n !== 1'b0 || cfg_interrupt_di !== 8'd2) begin
        errors++; $display("FAIL wait_hold: got n=%b di=%0d expected n=0 di=2", cfg_interrupt_n, cfg_interrupt_di);
      end
    end
    ack_now();
    checks++; if (cfg_interrupt_n !== 1'b1) begin errors++; $display("FAIL ack_release: got %b expected 1", cfg_interrupt_n); end
    repeat (6) tick();
  endtask

  task automatic test_coalesce();
    bit early;
    pkt_threshold = 16'd4;
    coalesce_timeout = 32'd1000;
    repeat (2) tick();
    early = 1'b0;
    for (int n = 0; n < 1005; n++) begin
      ch_event[0] = (n == 0 || n == 2 || n == 4);
      tick();
      if (n + 1 < 1005 && cfg_interrupt_n === 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL coalesce_early: got early request expected none before timeout"); end
    checks++; if (cfg_interrupt_n !== 1'b0) begin errors++; $display("FAIL coalesce_timeout: got %b expected 0", cfg_interrupt_n); end
    checks++; if (cfg_interrupt_di !== 8'd0) begin errors++; $display("FAIL coalesce_di: got %0d expected 0", cfg_interrupt_di); end
    ack_now();
    repeat (6) tick();
    for (int n = 0; n < 11; n++) begin
      ch_event[0] = (n == 0 || n == 2 || n == 4 || n == 6);
      tick();
      if (n == 9) begin
        checks++; if (cfg_interrupt_n !== 1'b1) begin errors++; $display("FAIL thresh4_early: got %b expected 1", cfg_interrupt_n); end
      end
    end
    checks++; if (cfg_interrupt_n !== 1'b0) begin errors++; $display("FAIL thresh4_req: got %b expected 0", cfg_interrupt_n); end
    ack_now();
    repeat (6) tick();
    pkt_threshold = 16'd1;
    repeat (2) tick();
  endtask

  task automatic rr_pair(input logic [3:0] ev, input logic [7:0] e0, input logic [7:0] e1);
    int t0, t1;
    logic [7:0] d0, d1;
    t0 = -1; t1 = -1; d0 = '0; d1 = '0;
    cfg_interrupt_rdy_n = 1'b0;
    ch_event = ev;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 1) ch_event = '0;
      if (cfg_interrupt_n === 1'b0) begin
        if (t0 < 0) begin t0 = t; d0 = cfg_interrupt_di; end
        else if (t1 < 0) begin t1 = t; d1 = cfg_interrupt_di; end
      end
    end
    cfg_interrupt_rdy_n = 1'b1;
    checks++; if (t0 != 5) begin errors++; $display("FAIL rr_first_time: got %0d expected 5", t0); end
    checks++; if (d0 !== e0) begin errors++; $display("FAIL rr_first_di: got %0d expected %0d", d0, e0); end
    checks++; if (d1 !== e1) begin errors++; $display("FAIL rr_second_di: got %0d expected %0d", d1, e1); end
    checks++; if (t1 - t0 != 2) begin errors++; $display("FAIL rr_spacing: got %0d expected 2", t1 - t0); end
  endtask

  task automatic test_round_robin();
    rr_pair(4'b1010, 8'd1, 8'd3);
    rr_pair(4'b1010, 8'd1, 8'd3);
    rr_pair(4'b0011, 8'd0, 8'd1);
  endtask

  task automatic test_holdoff();
    int n;
    bit early;
    interrupt_period = 32'd50;
    repeat (2) tick();
    ch_event[2] = 1'b1;
    tick();
    ch_event[2] = 1'b0;
    wait_cfg_low(10, n);
    checks++; if (n != 4) begin errors++; $display("FAIL holdoff_first: got %0d expected 4", n); end
    ack_now();
    early = 1'b0;
    for (int t = 1; t <= 53; t++) begin
      tick();
      ch_event[2] = (t == 1 || t == 3);
      if (t <= 52 && cfg_interrupt_n === 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL holdoff_early: got request during holdoff expected none"); end
    checks++; if (cfg_interrupt_n !== 1'b0) begin errors++; $display("FAIL holdoff_rearm: got %b expected 0", cfg_interrupt_n); end
    checks++; if (cfg_interrupt_di !== 8'd2) begin errors++; $display("FAIL holdoff_di: got %0d expected 2", cfg_interrupt_di); end
    ack_now();
    repeat (55) tick();
    checks++; if (cfg_interrupt_n !== 1'b1) begin errors++; $display("FAIL holdoff_idle: got %b expected 1", cfg_interrupt_n); end
    // Dropped grant: the channel still serves a full holdoff before re-arming.
    ch_ready[2] = 1'b0;
    ch_event[2] = 1'b1;
    early = 1'b0;
    for (int t = 1; t <= 58; t++) begin
      tick();
      ch_event[2] = (t == 10);
      if (t == 10) ch_ready[2] = 1'b1;
      if (t <= 57 && cfg_interrupt_n === 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL drop_early: got request expected none"); end
    checks++; if (cfg_interrupt_n !== 1'b0) begin errors++; $display("FAIL drop_hold_exit: got %b expected 0", cfg_interrupt_n); end
    ack_now();
    interrupt_period = 32'd2;
    repeat (8) tick();
  endtask

  task automatic test_resend();
    int n;
    ch_enable[1]  = 1'b0;
    resend_req[1] = 1'b1;
    ch_event[2]   = 1'b1;
    tick();
    checks++; if (resend_ack !== 4'b0010) begin errors++; $display("FAIL resend_ack_pulse: got %b expected 0010", resend_ack); end
    resend_req[1] = 1'b0;
    ch_event[2]   = 1'b0;
    tick();
    checks++; if (resend_ack !== 4'b0000) begin errors++; $display("FAIL resend_ack_single: got %b expected 0000", resend_ack); end
    wait_cfg_low(10, n);
    checks++; if (n != 3) begin errors++; $display("FAIL resend_other_time: got %0d expected 3", n); end
    checks++; if (cfg_interrupt_di !== 8'd2) begin errors++; $display("FAIL resend_other_di: got %0d expected 2", cfg_interrupt_di); end
    ack_now();
    repeat (6) tick();
    checks++; if (cfg_interrupt_n !== 1'b1) begin errors++; $display("FAIL resend_disabled_wait: got %b expected 1", cfg_interrupt_n); end
    ch_enable[1] = 1'b1;
    ch_ready[1]  = 1'b0;
    tick();
    checks++; if (cfg_interrupt_n !== 1'b0) begin errors++; $display("FAIL resend_forced_issue: got %b expected 0", cfg_interrupt_n); end
    checks++; if (cfg_interrupt_di !== 8'd1) begin errors++; $display("FAIL resend_forced_di: got %0d expected 1", cfg_interrupt_di); end
    ack_now();
    ch_ready[1] = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_reset_mid();
    int n;
    bit spurious;
    ch_event = 4'b1001;
    tick();
    ch_event = '0;
    wait_cfg_low(10, n);
    checks++; if (n != 4) begin errors++; $display("FAIL mid_req_time: got %0d expected 4", n); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (cfg_interrupt_n !== 1'b1) begin errors++; $display("FAIL mid_async_release: got %b expected 1", cfg_interrupt_n); end
    checks++; if (cfg_interrupt_di !== 8'd0) begin errors++; $display("FAIL mid_async_di: got %0d expected 0", cfg_interrupt_di); end
    repeat (2) tick();
    reset_n = 1'b1;
    spurious = 1'b0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (cfg_interrupt_n === 1'b0) spurious = 1'b1;
    end
    checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL mid_spurious: got request after reset expected none"); end
    ch_event[3] = 1'b1;
    tick();
    ch_event[3] = 1'b0;
    wait_cfg_low(10, n);
    checks++; if (n != 4) begin errors++; $display("FAIL mid_resume_time: got %0d expected 4", n); end
    checks++; if (cfg_interrupt_di !== 8'd3) begin errors++; $display("FAIL mid_resume_di: got %0d expected 3", cfg_interrupt_di); end
    ack_now();
    repeat (4) tick();
  endtask

  initial begin
    cfg_interrupt_rdy_n = 1'b1;
    ch_event            = '0;
    ch_ready            = '1;
    ch_enable           = '1;
    resend_req          = '0;
    pkt_threshold       = 16'd1;
    coalesce_timeout    = 32'd1000;
    interrupt_period    = 32'd2;
    test_reset();
    test_threshold_issue();
    test_coalesce();
    test_round_robin();
    test_holdoff();
    test_resend();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
